universal_register_array: RTL and testbench
===========================================

Name: universal_register_array

Overview:
- Parameterised single-clock register array with one write port and one read port.
- Holds 2**DEPTH words of DATA_WIDTH bits; addresses are DEPTH bits wide.
- After every reset it runs an initialisation sweep that zeroes all entries, with busy asserted for the whole sweep.
- Sits as a general-purpose storage block behind a simple enable/address/data request interface.

Parameters:
- DEPTH, 4, address width in bits; the array holds 2**DEPTH entries.
- DATA_WIDTH, 8, width of each stored word in bits.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- rst  input  1  reset, asynchronous and active-high.
- read_addr  input  DEPTH  entry index for a read.
- write_addr  input  DEPTH  entry index for a write.
- write_data  input  DATA_WIDTH  word to store.
- write_en  input  1  write request, sampled at the rising edge.
- read_en  input  1  read request, sampled at the rising edge.
- read_data  output  DATA_WIDTH  registered read result.
- busy  output  1  high while initialising; requests are ignored while high.

Behaviour:
- One clock (clk). Reset (rst) is asynchronous and active-high.
- Storage: 2**DEPTH x DATA_WIDTH flops or RAM. Storage itself is not reset; it is cleared by the sweep.
- While rst is high, immediately and independent of clk:
  - read_data = 0.
  - busy = 1.
  - sweep counter = 0.
- Init sweep:
  - Starts at the first rising edge after rst falls.
  - Edge k (k = 0 .. 2**DEPTH-1) writes 0 into entry k.
  - busy is a registered output and drops to 0 at the same edge that clears the last entry.
  - busy is therefore high for exactly 2**DEPTH rising edges after reset release.
- Requests while busy = 1: read_en and write_en are ignored. No storage write occurs (other than the sweep) and read_data holds.
- Write, when busy = 0 and write_en = 1: entry[write_addr] <= write_data at the rising edge.
- Read, when busy = 0 and read_en = 1:
  - read_data <= entry[read_addr] at the rising edge, giving 1-cycle latency.
  - Data is valid after that edge and held until the next accepted read or a reset.
- Read with read_en = 0: read_data holds its last value.
- Same-cycle read and write:
  - Same address: read_data takes write_data (write-first bypass) and the entry is updated.
  - Different addresses: both operations complete independently.
- All 2**DEPTH addresses are valid. No out-of-range condition and no wrap behaviour beyond the address width.
- No X propagation: busy and read_data are always defined after reset.
- Reset mid-operation (mid-sweep or during normal traffic):
  - Outputs return to their reset values immediately.
  - Any in-flight request is discarded.
  - The sweep restarts from entry 0 after release, so all prior contents are lost.

Test Plan (DEPTH=4, DATA_WIDTH=8, 16 entries):
1. Reset and sweep: assert rst, then release.
   - During rst: busy=1, read_data=0x00.
   - busy remains 1 for 16 rising edges after release, then 0.
2. Cleared contents: after init, read addresses 0..15 one per cycle -> each read_data=0x00, one cycle after its read edge.
3. Write then read:
   - Write 0xA5 to addr 3, then read addr 3 -> read_data=0xA5 on the edge after the read edge.
   - Read addr 4 -> 0x00.
4. Same-address collision: write_en=1, write_addr=7, write_data=0x3C with read_en=1, read_addr=7 in the same cycle -> read_data=0x3C after that edge; a later read of addr 7 -> 0x3C.
5. Requests during busy: write 0x55 to addr 2 and read addr 2 during the sweep.
   - read_data stays 0x00 throughout.
   - After busy falls, a read of addr 2 -> 0x00.
6. Reset mid-operation: write 0xFF to addr 15, read it (read_data=0xFF), then assert rst between clock edges.
   - read_data=0x00 and busy=1 immediately.
   - After release and the 16-edge sweep, a read of addr 15 -> 0x00.

Source files
------------

// File: rtl/universal_register_array.sv
// Single-clock register array with one write and one read port.
// A zeroing sweep runs after every reset; requests are ignored while busy.
module universal_register_array #(
    parameter int DEPTH      = 4,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DEPTH-1:0]      read_addr,
    input  logic [DEPTH-1:0]      write_addr,
    input  logic [DATA_WIDTH-1:0] write_data,
    input  logic                  write_en,
    input  logic                  read_en,
    output logic [DATA_WIDTH-1:0] read_data,
    output logic                  busy
);

    localparam int ENTRIES = 1 << DEPTH;

    logic [DATA_WIDTH-1:0] mem_q [ENTRIES];

    logic [DEPTH-1:0]      sweep_q, sweep_d;
    logic                  busy_q, busy_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

    logic                  wr_go, rd_go;
    logic                  mem_we;
    logic [DEPTH-1:0]      mem_waddr;
    logic [DATA_WIDTH-1:0] mem_wdata;

    always_comb begin
        wr_go     = !busy_q && write_en;
        rd_go     = !busy_q && read_en;
        sweep_d   = sweep_q;
        busy_d    = busy_q;
        rdata_d   = rdata_q;
        mem_we    = wr_go;
        mem_waddr = write_addr;
        mem_wdata = write_data;
        // The sweep owns the write port until the last entry is cleared.
        if (busy_q) begin
            mem_we    = 1'b1;
            mem_waddr = sweep_q;
            mem_wdata = '0;
            sweep_d   = sweep_q + DEPTH'(1);
            if (&sweep_q) begin
                busy_d = 1'b0;
            end
        end
        if (rd_go) begin
            if (wr_go && (write_addr == read_addr)) begin
                rdata_d = write_data;
            end else begin
                rdata_d = mem_q[read_addr];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sweep_q <= '0;
            busy_q  <= 1'b1;
            rdata_q <= '0;
        end else begin
            sweep_q <= sweep_d;
            busy_q  <= busy_d;
            rdata_q <= rdata_d;
        end
    end

    // Storage is deliberately not reset; the sweep clears it.
    always_ff @(posedge clk) begin
        if (!rst && mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

    assign read_data = rdata_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_universal_register_array.sv
// Bench for universal_register_array: behavioural model plus
// directed vectors with literal expectations.
module tb_universal_register_array;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] read_addr;
    logic [3:0] write_addr;
    logic [7:0] write_data;
    logic       write_en;
    logic       read_en;
    logic [7:0] read_data;
    logic       busy;

    int tests = 0;
    int fails = 0;
    bit started = 1'b0;

    logic [7:0] m_mem [16];
    logic [7:0] m_rd;
    logic       m_busy;
    int         m_cleared;

    universal_register_array #(.DEPTH(4), .DATA_WIDTH(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .read_addr  (read_addr),
        .write_addr (write_addr),
        .write_data (write_data),
        .write_en   (write_en),
        .read_en    (read_en),
        .read_data  (read_data),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: reset clears outputs; the first 16 edges after release zero
    // entries in order, then reads/writes follow the port rules.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_rd      = 8'h00;
            m_busy    = 1'b1;
            m_cleared = 0;
        end else if (m_busy) begin
            m_mem[m_cleared] = 8'h00;
            m_cleared        = m_cleared + 1;
            if (m_cleared == 16) m_busy = 1'b0;
        end else begin
            if (read_en) begin
                if (write_en && write_addr == read_addr) m_rd = write_data;
                else m_rd = m_mem[read_addr];
            end
            if (write_en) m_mem[write_addr] = write_data;
        end
    end

    always @(negedge clk) begin
        if (started) begin
            check("model_read_data", {24'h0, read_data}, {24'h0, m_rd});
            check("model_busy", {31'h0, busy}, {31'h0, m_busy});
        end
    end

    task automatic op(input logic we, input logic [3:0] wa,
                      input logic [7:0] wd, input logic re,
                      input logic [3:0] ra);
        @(negedge clk);
        write_en   = we;
        write_addr = wa;
        write_data = wd;
        read_en    = re;
        read_addr  = ra;
        @(negedge clk);
        write_en = 1'b0;
        read_en  = 1'b0;
    endtask

    task automatic sweep_len(output int n);
        n = 0;
        while (busy === 1'b1 && n < 40) begin
            @(posedge clk);
            n++;
            #1;
        end
    endtask

    initial begin
        int n;
        rst        = 1'b1;
        read_addr  = '0;
        write_addr = '0;
        write_data = '0;
        write_en   = 1'b0;
        read_en    = 1'b0;
        #1 started = 1'b1;
        repeat (2) @(negedge clk);
        check("reset_read_data", {24'h0, read_data}, 32'h00);
        check("reset_busy", {31'h0, busy}, 32'h1);

        // Requests during the sweep must be ignored
        rst        = 1'b0;
        write_en   = 1'b1;
        write_addr = 4'd2;
        write_data = 8'h55;
        read_en    = 1'b1;
        read_addr  = 4'd2;
        sweep_len(n);
        check("sweep_edges", n, 32'd16);
        @(negedge clk);
        write_en = 1'b0;
        read_en  = 1'b0;
        check("busy_rd_held", {24'h0, read_data}, 32'h00);

        for (int a = 0; a < 16; a++) begin
            op(1'b0, 4'd0, 8'h00, 1'b1, 4'(a));
            check($sformatf("cleared_%0d", a), {24'h0, read_data}, 32'h00);
        end

        op(1'b1, 4'd3, 8'hA5, 1'b0, 4'd0);
        op(1'b0, 4'd0, 8'h00, 1'b1, 4'd3);
        check("wr_rd_3", {24'h0, read_data}, 32'hA5);
        op(1'b0, 4'd0, 8'h00, 1'b1, 4'd4);
        check("rd_4", {24'h0, read_data}, 32'h00);

        op(1'b1, 4'd7, 8'h3C, 1'b1, 4'd7);
        check("bypass_7", {24'h0, read_data}, 32'h3C);
        op(1'b0, 4'd0, 8'h00, 1'b1, 4'd7);
        check("rd_7", {24'h0, read_data}, 32'h3C);

        op(1'b1, 4'd8, 8'h11, 1'b1, 4'd3);
        check("diff_addr_rd", {24'h0, read_data}, 32'hA5);
        op(1'b1, 4'd9, 8'h22, 1'b0, 4'd8);
        check("hold_no_rd", {24'h0, read_data}, 32'hA5);
        op(1'b0, 4'd0, 8'h00, 1'b1, 4'd8);
        check("rd_8", {24'h0, read_data}, 32'h11);

        // Reset in the middle of a sweep restarts it from entry 0
        @(posedge clk);
        #2 rst = 1'b1;
        #1 check("rst_busy_a", {31'h0, busy}, 32'h1);
        @(negedge clk) rst = 1'b0;
        repeat (5) @(posedge clk);
        #2 rst = 1'b1;
        #1 check("midsweep_busy", {31'h0, busy}, 32'h1);
        @(negedge clk) rst = 1'b0;
        sweep_len(n);
        check("resweep_edges", n, 32'd16);
        op(1'b0, 4'd0, 8'h00, 1'b1, 4'd3);
        check("rd_3_lost", {24'h0, read_data}, 32'h00);

        op(1'b1, 4'd15, 8'hFF, 1'b0, 4'd0);
        op(1'b0, 4'd0, 8'h00, 1'b1, 4'd15);
        check("rd_15_ff", {24'h0, read_data}, 32'hFF);
        @(posedge clk);
        #2 rst = 1'b1;
        #1 check("async_rd_zero", {24'h0, read_data}, 32'h00);
        check("async_busy", {31'h0, busy}, 32'h1);
        @(negedge clk) rst = 1'b0;
        sweep_len(n);
        check("final_sweep_edges", n, 32'd16);
        op(1'b0, 4'd0, 8'h00, 1'b1, 4'd15);
        check("rd_15_cleared", {24'h0, read_data}, 32'h00);

        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
